// File: rtl/lfsr_seq_ctrl.sv
// Command-driven sequencer around a W-bit Fibonacci LFSR.
// Emits one burst of cmd_len pseudo-random words per command and then pulses done with status.
module lfsr_seq_ctrl #(
   parameter int               W            = 4,
   parameter int               CNT_W        = 8,
   parameter logic [W-1:0]     DEFAULT_TAPS = 4'b1100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [W-1:0]     cmd_seed,
   input  logic [W-1:0]     cmd_taps,
   input  logic [CNT_W-1:0] cmd_len,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_last,
   output logic             done,
   output logic             aborted,
   output logic             seed_fixed,
   output logic [CNT_W-1:0] beats
);

   // state  | meaning
   // S_IDLE | waiting for a command, cmd_ready high
   // S_RUN  | presenting LFSR words on the output stream
   // S_DONE | one-cycle done pulse, status registers stable
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     lfsr_q, lfsr_d;
   logic [W-1:0]     taps_q, taps_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] beats_q, beats_d;
   logic             aborted_q, aborted_d;
   logic             seed_fixed_q, seed_fixed_d;

   logic             is_last;
   logic             fb;
   logic [W-1:0]     lfsr_next;

   assign is_last   = (remaining_q == CNT_W'(1));
   assign fb        = ^(lfsr_q & taps_q);
   assign lfsr_next = {lfsr_q[W-2:0], fb};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lfsr_q       <= '0;
         taps_q       <= '0;
         remaining_q  <= '0;
         beats_q      <= '0;
         aborted_q    <= 1'b0;
         seed_fixed_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         taps_q       <= taps_d;
         remaining_q  <= remaining_d;
         beats_q      <= beats_d;
         aborted_q    <= aborted_d;
         seed_fixed_q <= seed_fixed_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      taps_d       = taps_q;
      remaining_d  = remaining_q;
      beats_d      = beats_q;
      aborted_d    = aborted_q;
      seed_fixed_d = seed_fixed_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               taps_d       = (cmd_taps == '0) ? DEFAULT_TAPS : cmd_taps;
               lfsr_d       = (cmd_seed == '0) ? W'(1) : cmd_seed;
               seed_fixed_d = (cmd_seed == '0);
               remaining_d  = cmd_len;
               beats_d      = '0;
               aborted_d    = 1'b0;
               state_d      = (cmd_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (out_ready) begin
               beats_d     = beats_q + CNT_W'(1);
               remaining_d = remaining_q - CNT_W'(1);
               lfsr_d      = lfsr_next;
            end
            // A beat that completes the burst wins over a coincident abort.
            if (abort) begin
               aborted_d = !(out_ready && is_last);
               state_d   = S_DONE;
            end else if (out_ready && is_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      cmd_ready  = (state_q == S_IDLE) && !rst;
      out_valid  = (state_q == S_RUN);
      out_data   = (state_q == S_RUN) ? lfsr_q : '0;
      out_last   = (state_q == S_RUN) && is_last;
      done       = (state_q == S_DONE);
      aborted    = aborted_q;
      seed_fixed = seed_fixed_q;
      beats      = beats_q;
   end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: directed command table, randomized bursts against a
// word-level reference model, plus reset and idle-abort sequences.
module tb_lfsr_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_seed;
   logic [3:0] cmd_taps;
   logic [7:0] cmd_len;
   logic       abort;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_last;
   logic       done;
   logic       aborted;
   logic       seed_fixed;
   logic [7:0] beats;

   int checks = 0;
   int errors = 0;

   logic [3:0] obs[$];

   typedef struct {
      int seed;
      int taps;
      int len;
      int rmode;
      int abort_at;
      int abort_rdy;
      int exp_beats;
      int exp_aborted;
      int exp_fixed;
   } vec_t;

   vec_t vt[8];
   int   seq15[15];

   lfsr_seq_ctrl #(.W(4), .CNT_W(8), .DEFAULT_TAPS(4'b1100)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_seed   (cmd_seed),
      .cmd_taps   (cmd_taps),
      .cmd_len    (cmd_len),
      .abort      (abort),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .done       (done),
      .aborted    (aborted),
      .seed_fixed (seed_fixed),
      .beats      (beats)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Next LFSR value: parity of tapped bits shifted into the bottom of a 4-bit register.
   function automatic int model_next(input int s, input int t);
      int ones = 0;
      for (int b = 0; b < 4; b++)
         if (((s >> b) & 1) == 1 && ((t >> b) & 1) == 1) ones++;
      return ((s * 2) % 16) + (ones % 2);
   endfunction

   task automatic run_cmd(input int seed, input int taps, input int len, input int rmode,
                          input int abort_at, input int abort_rdy, input bit rand_abort,
                          output int m_beats, output int m_aborted);
      int st, tp, rem, nb, cyc;
      bit ab, rdy, abt, fin;
      logic [3:0] d;
      obs.delete();
      cyc = 0;
      while (!cmd_ready && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("cmd_ready_before_accept", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_seed  = 4'(seed);
      cmd_taps  = 4'(taps);
      cmd_len   = 8'(len);
      tick();
      cmd_valid = 1'b0;
      cmd_seed  = 4'($urandom);
      cmd_taps  = 4'($urandom);
      cmd_len   = 8'($urandom);
      st  = (seed == 0) ? 1 : seed;
      tp  = (taps == 0) ? 12 : taps;
      rem = len;
      nb  = 0;
      ab  = 1'b0;
      fin = (len == 0);
      cyc = 0;
      while (!fin) begin
         chk("out_valid_run", int'(out_valid), 1);
         chk("out_data", int'(out_data), st);
         chk("out_last", int'(out_last), int'(rem == 1));
         chk("done_in_run", int'(done), 0);
         chk("cmd_ready_in_run", int'(cmd_ready), 0);
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = ($urandom_range(0, 2) != 0);
         endcase
         abt = rand_abort && ($urandom_range(0, 15) == 0);
         if (abort_at >= 0 && nb == abort_at) begin
            abt = 1'b1;
            rdy = abort_rdy[0];
         end
         out_ready = rdy;
         abort     = abt;
         d         = out_data;
         tick();
         out_ready = 1'b0;
         abort     = 1'b0;
         if (rdy) begin
            obs.push_back(d);
            nb++;
            rem--;
            st = model_next(st, tp);
         end
         if (abt) begin
            ab  = !(rdy && rem == 0);
            fin = 1'b1;
         end else if (rdy && rem == 0) begin
            fin = 1'b1;
         end
         cyc++;
         if (!fin && cyc > 400) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: got %0d cycles expected completion", cyc);
            fin = 1'b1;
         end
      end
      chk("done_pulse", int'(done), 1);
      chk("out_valid_done", int'(out_valid), 0);
      chk("cmd_ready_done", int'(cmd_ready), 0);
      chk("beats", int'(beats), nb);
      chk("aborted", int'(aborted), int'(ab));
      chk("seed_fixed", int'(seed_fixed), int'(seed == 0));
      tick();
      chk("done_one_cycle", int'(done), 0);
      chk("cmd_ready_after_done", int'(cmd_ready), 1);
      chk("beats_hold", int'(beats), nb);
      chk("aborted_hold", int'(aborted), int'(ab));
      m_beats   = nb;
      m_aborted = int'(ab);
   endtask

   initial begin
      int mb, ma;
      rst = 1'b1; cmd_valid = 1'b0; cmd_seed = '0; cmd_taps = '0; cmd_len = '0;
      abort = 1'b0; out_ready = 1'b0;

      seq15 = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
      //          seed taps len rmode abort_at rdy beats ab fix
      vt[0] = '{1,  12,  4,  0, -1, 0,  4, 0, 0};
      vt[1] = '{1,  0,  15,  0, -1, 0, 15, 0, 0};
      vt[2] = '{0,  12,  2,  0, -1, 0,  2, 0, 1};
      vt[3] = '{5,  12,  4,  1, -1, 0,  4, 0, 0};
      vt[4] = '{3,  12, 10,  0,  3, 0,  3, 1, 0};
      vt[5] = '{7,  12,  4,  0,  3, 1,  4, 0, 0};
      vt[6] = '{2,  12,  0,  0, -1, 0,  0, 0, 0};
      vt[7] = '{9,  9,   6,  1,  2, 1,  3, 1, 0};

      tick();
      tick();
      chk("rst_cmd_ready", int'(cmd_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_aborted", int'(aborted), 0);
      chk("rst_seed_fixed", int'(seed_fixed), 0);
      chk("rst_beats", int'(beats), 0);
      rst = 1'b0;
      tick();
      chk("cmd_ready_after_rst", int'(cmd_ready), 1);

      for (int i = 0; i < 8; i++) begin
         run_cmd(vt[i].seed, vt[i].taps, vt[i].len, vt[i].rmode, vt[i].abort_at,
                 vt[i].abort_rdy, 1'b0, mb, ma);
         chk("tbl_beats", int'(beats), vt[i].exp_beats);
         chk("tbl_aborted", int'(aborted), vt[i].exp_aborted);
         chk("tbl_seed_fixed", int'(seed_fixed), vt[i].exp_fixed);
         if (i <= 2) begin
            chk("seq_len", obs.size(), vt[i].len);
            for (int k = 0; k < obs.size() && k < 15; k++)
               chk("seq_word", int'(obs[k]), seq15[k]);
         end
      end

      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort_ready", int'(cmd_ready), 1);
      chk("idle_abort_done", int'(done), 0);
      chk("idle_abort_status", int'(aborted), vt[7].exp_aborted);

      for (int r = 0; r < 30; r++)
         run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 20)), 2, -1, 0, 1'b1, mb, ma);

      cmd_valid = 1'b1; cmd_seed = 4'd6; cmd_taps = 4'd12; cmd_len = 8'd8;
      tick();
      cmd_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      chk("pre_rst_running", int'(out_valid), 1);
      chk("pre_rst_beats", int'(beats), 3);
      rst = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_cmd_ready", int'(cmd_ready), 0);
      chk("midrst_out_data", int'(out_data), 0);
      chk("midrst_beats", int'(beats), 0);
      rst = 1'b0;
      tick();
      chk("postrst_cmd_ready", int'(cmd_ready), 1);
      chk("postrst_done", int'(done), 0);
      chk("postrst_out_valid", int'(out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
